biu_ctrl: RTL and testbench
===========================

BIU_CTRL -- requirements
Module: biu_ctrl

Interface
REQ-001 Parameter: MEM_IOM, default 0, IOM level driven for memory cycles; I/O cycles drive the inverse.
REQ-002 Clocking and reset: one clock, CLK; reset is RESET, asynchronous and active-high.
REQ-003 Port list, request side:
- CLK  in  1  clock.
- RESET  in  1  async active-high reset.
- req_valid  in  1  request offered.
- req_ready  out  1  holding register empty; request accepted on an edge with req_valid&&req_ready.
- req_write  in  1  1=write, 0=read.
- req_io  in  1  1=I/O cycle, 0=memory cycle.
- req_addr  in  20  byte address.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  last read data.
- busy  out  1  bus cycle in progress (state != IDLE).
REQ-004 Port list, bus side:
- Address  out  20  bus address.
- Data  inout  8  bidirectional data bus.
- ALE  out  1  address latch enable, high in T1 only.
- RD  out  1  active-low read strobe.
- WR  out  1  active-low write strobe.
- IOM  out  1  memory/I-O select.
- CS0  out  1  select for 0x00000-0x7FFFF.
- CS1  out  1  select for 0x80000-0xFFFFF.

Function
REQ-005 One-entry holding register captures write, io, addr and wdata on the accepting edge; req_ready = !hold_full.
REQ-006 FSM states are IDLE, T1, T2, T3 and T4, with these transitions:
- IDLE->T1 when hold_full.
- T1->T2, T2->T3, T3->T4 unconditionally.
- T4->T1 if hold_full, else T4->IDLE.
REQ-007 On entry to T1, the holding entry moves into the cycle registers and hold_full clears the same edge, so a new request is acceptable during T1.
REQ-008 A request accepted in the same edge as T4->IDLE is launched one cycle later (IDLE->T1).
REQ-009 Address is driven from the cycle registers during T1-T4 and holds its last value in IDLE.
REQ-010 ALE=1 in T1 only.
REQ-011 IOM = MEM_IOM for memory cycles and ~MEM_IOM for I/O cycles, valid T1-T4.
REQ-012 For memory cycles, CS1=Address[19] and CS0=~Address[19] during T1-T4.
REQ-013 For I/O cycles, and in IDLE, CS0=CS1=0.
REQ-014 Read strobes: RD=0 in T2 and T3, else 1.
REQ-015 Write strobes: WR=0 in T2 and T3, else 1; RD and WR are never low together.
REQ-016 Data is driven with wdata during T2-T3 of write cycles only; otherwise it is high-impedance.
REQ-017 The read cycle samples Data on the T3->T4 edge into rsp_rdata.
REQ-018 rsp_rdata is unchanged by writes and I/O writes.
REQ-019 rsp_valid=1 for exactly the T4 cycle of every bus cycle, read or write.
REQ-020 Latency: request accepted at edge e from IDLE gives T1 in cycle e+1 and rsp_valid in cycle e+4.
REQ-021 Back-to-back requests produce cycles every 4 clocks with no IDLE gap.
REQ-022 req_valid with req_ready=0 has no effect; the requester holds it.
REQ-023 busy=1 in T1-T4.

Reset
REQ-024 On RESET, asynchronously and regardless of state:
- FSM=IDLE, hold_full=0.
- ALE=0, RD=1, WR=1, CS0=CS1=0.
- IOM=MEM_IOM, Address=0.
- Data=Z.
- rsp_valid=0, rsp_rdata=0, busy=0.
REQ-025 Reset mid-cycle aborts the cycle: no rsp_valid is produced, and the pending holding entry is discarded.
REQ-026 After RESET deasserts, req_ready=1 in the first clock.

Verification
REQ-027 Read at 0x80010 with the memory model returning 0xA5 -> ALE high 1 cycle, CS1=1, CS0=0, RD low 2 cycles, rsp_valid in cycle e+4, rsp_rdata=0xA5.
REQ-028 Write 0x3C to 0x80020, then read 0x80020 -> Data=0x3C during T2-T3 with WR low, Data=Z after; the read returns 0x3C.
REQ-029 Three back-to-back requests with req_valid held high -> bus cycles start at e+1, e+5 and e+9; three rsp_valid pulses 4 cycles apart; req_ready low while the holding register is full.
REQ-030 I/O read at 0x00040 -> IOM=~MEM_IOM, CS0=CS1=0, RD low T2-T3, rsp_valid asserted once.
REQ-031 RESET asserted during T3 of a write -> WR=1 and Data=Z immediately (asynchronous), no rsp_valid, busy=0, queued request dropped.
REQ-032 Address 0x7FFFF then 0x80000 -> CS0 then CS1 selected; the boundary decode is exact.

Source files
------------

// File: rtl/biu_ctrl.sv
// biu_ctrl: single-entry request buffer driving a classic
// T1-T4 multiplexed-style bus cycle (ALE, RD/WR strobes, chip selects).
module biu_ctrl #(
    parameter logic MEM_IOM = 1'b0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_io,
    input  logic [19:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        busy,
    output logic [19:0] Address,
    inout  wire  [7:0]  Data,
    output logic        ALE,
    output logic        RD,
    output logic        WR,
    output logic        IOM,
    output logic        CS0,
    output logic        CS1
);

    typedef enum logic [2:0] {
        IDLE,
        T1,
        T2,
        T3,
        T4
    } state_t;

    state_t state;
    state_t state_nx;

    logic        hold_full;
    logic        hold_write;
    logic        hold_io;
    logic [19:0] hold_addr;
    logic [7:0]  hold_wdata;

    logic        cyc_write;
    logic        cyc_io;
    logic [19:0] cyc_addr;
    logic [7:0]  cyc_wdata;

    logic        accept;
    logic        launch;
    logic        drive;

    assign req_ready = !hold_full;
    assign accept    = req_valid && !hold_full;
    assign launch    = (state_nx == T1);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (hold_full) state_nx = T1;
            T1:      state_nx = T2;
            T2:      state_nx = T3;
            T3:      state_nx = T4;
            T4:      state_nx = hold_full ? T1 : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Launch and accept are exclusive: launch needs a full entry, accept an empty one.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hold_full  <= 1'b0;
            hold_write <= 1'b0;
            hold_io    <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
        end else if (launch) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_full  <= 1'b1;
            hold_write <= req_write;
            hold_io    <= req_io;
            hold_addr  <= req_addr;
            hold_wdata <= req_wdata;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cyc_write <= 1'b0;
            cyc_io    <= 1'b0;
            cyc_addr  <= '0;
            cyc_wdata <= '0;
        end else if (launch) begin
            cyc_write <= hold_write;
            cyc_io    <= hold_io;
            cyc_addr  <= hold_addr;
            cyc_wdata <= hold_wdata;
        end
    end

    // Read data is captured as the strobe deasserts (T3 -> T4).
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rsp_rdata <= '0;
        end else if (state == T3 && !cyc_write) begin
            rsp_rdata <= Data;
        end
    end

    always_comb begin
        ALE   = 1'b0;
        RD    = 1'b1;
        WR    = 1'b1;
        IOM   = MEM_IOM;
        CS0   = 1'b0;
        CS1   = 1'b0;
        drive = 1'b0;
        if (state != IDLE) begin
            IOM = cyc_io ? ~MEM_IOM : MEM_IOM;
            CS1 = !cyc_io && cyc_addr[19];
            CS0 = !cyc_io && !cyc_addr[19];
        end
        unique case (state)
            T1: ALE = 1'b1;
            T2, T3: begin
                RD    = cyc_write;
                WR    = !cyc_write;
                drive = cyc_write;
            end
            default: ;
        endcase
    end

    assign Address   = cyc_addr;
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == T4);
    assign Data      = drive ? cyc_wdata : 8'hzz;

endmodule

// File: tb/tb_biu_ctrl.sv
// tb_biu_ctrl: table-driven single cycles plus back-to-back
// and mid-cycle reset sequences against a small memory model.
module tb_biu_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_io;
    logic [19:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        busy;
    logic [19:0] Address;
    wire  [7:0]  Data;
    logic        ALE;
    logic        RD;
    logic        WR;
    logic        IOM;
    logic        CS0;
    logic        CS1;

    biu_ctrl #(.MEM_IOM(1'b0)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_io    (req_io),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .Address   (Address),
        .Data      (Data),
        .ALE       (ALE),
        .RD        (RD),
        .WR        (WR),
        .IOM       (IOM),
        .CS0       (CS0),
        .CS1       (CS1)
    );

    always #5 CLK = ~CLK;

    // Memory model: 256 bytes aliased on Address[7:0].
    logic [7:0] mem [256];
    assign Data = (!RD) ? mem[Address[7:0]] : 8'hzz;
    always @(negedge CLK) if (!WR) mem[Address[7:0]] = Data;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic mon_en = 1'b0;
    int   ale_at[$];
    int   rsp_at[$];
    always @(negedge CLK) begin
        if (mon_en) begin
            if (ALE) ale_at.push_back(cyc);
            if (rsp_valid) rsp_at.push_back(cyc);
        end
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic        wr;
        logic        io;
        logic [19:0] addr;
        logic [7:0]  wdata;
        logic        cs0;
        logic        cs1;
        logic        iom;
        logic [7:0]  rdata;
    } vec_t;

    vec_t vt[9];

    task automatic run_vec(input vec_t v, input int idx);
        string s;
        s = $sformatf("v%0d", idx);
        req_write = v.wr;
        req_io    = v.io;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk({s, " busy_e0"}, busy, 0);
        chk({s, " ready_e0"}, req_ready, 0);
        step();
        chk({s, " ALE_T1"}, ALE, 1);
        chk({s, " busy_T1"}, busy, 1);
        chk({s, " Address"}, Address, v.addr);
        chk({s, " CS0"}, CS0, v.cs0);
        chk({s, " CS1"}, CS1, v.cs1);
        chk({s, " IOM"}, IOM, v.iom);
        chk({s, " RD_T1"}, RD, 1);
        step();
        chk({s, " ALE_T2"}, ALE, 0);
        chk({s, " RD_T2"}, RD, v.wr);
        chk({s, " WR_T2"}, WR, !v.wr);
        if (v.wr) chk({s, " Data_wr"}, Data, v.wdata);
        else chk({s, " Data_rd"}, Data, v.rdata);
        step();
        chk({s, " RD_T3"}, RD, v.wr);
        chk({s, " WR_T3"}, WR, !v.wr);
        chk({s, " rsp_T3"}, rsp_valid, 0);
        step();
        chk({s, " rsp_T4"}, rsp_valid, 1);
        chk({s, " rdata"}, rsp_rdata, v.rdata);
        chk({s, " RD_T4"}, RD, 1);
        chk({s, " WR_T4"}, WR, 1);
        step();
        chk({s, " rsp_end"}, rsp_valid, 0);
        chk({s, " busy_end"}, busy, 0);
    endtask

    int e;
    int n;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'hA5;
        mem[8'h40] = 8'h5A;
        mem[8'hFF] = 8'hC3;
        mem[8'h00] = 8'h11;

        //        wr    io    addr      wdata  cs0   cs1   iom   rdata
        vt[0] = '{1'b0, 1'b0, 20'h80010, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5};
        vt[1] = '{1'b1, 1'b0, 20'h80020, 8'h3C, 1'b0, 1'b1, 1'b0, 8'hA5};
        vt[2] = '{1'b0, 1'b0, 20'h80020, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C};
        vt[3] = '{1'b0, 1'b1, 20'h00040, 8'h00, 1'b0, 1'b0, 1'b1, 8'h5A};
        vt[4] = '{1'b1, 1'b1, 20'h00041, 8'h77, 1'b0, 1'b0, 1'b1, 8'h5A};
        vt[5] = '{1'b0, 1'b0, 20'h7FFFF, 8'h00, 1'b1, 1'b0, 1'b0, 8'hC3};
        vt[6] = '{1'b0, 1'b0, 20'h80000, 8'h00, 1'b0, 1'b1, 1'b0, 8'h11};
        vt[7] = '{1'b1, 1'b0, 20'h00005, 8'h99, 1'b1, 1'b0, 1'b0, 8'h11};
        vt[8] = '{1'b0, 1'b0, 20'h00005, 8'h00, 1'b1, 1'b0, 1'b0, 8'h99};

        RESET     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_io    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        #12;
        chk("rst ALE", ALE, 0);
        chk("rst RD", RD, 1);
        chk("rst WR", WR, 1);
        chk("rst CS0", CS0, 0);
        chk("rst CS1", CS1, 0);
        chk("rst IOM", IOM, 0);
        chk("rst Address", Address, 0);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst rsp_rdata", rsp_rdata, 0);
        chk("rst busy", busy, 0);
        RESET = 1'b0;
        step();
        chk("ready after reset", req_ready, 1);

        for (int i = 0; i < 9; i++) run_vec(vt[i], i);

        // Three back-to-back requests with req_valid held high.
        ale_at.delete();
        rsp_at.delete();
        mon_en = 1'b1;
        e = 0;
        for (int k = 0; k < 3; k++) begin
            req_write = (k == 1);
            req_io    = 1'b0;
            req_addr  = (k == 0) ? 20'h80010 : 20'h00030;
            req_wdata = 8'h44;
            req_valid = 1'b1;
            n = 0;
            while (!req_ready && n < 20) begin
                step();
                n++;
            end
            if (n >= 20) chk($sformatf("b2b ready timeout %0d", k), 0, 1);
            step();
            if (k == 0) e = cyc;
            if (k == 1) chk("b2b ready while full", req_ready, 0);
        end
        req_valid = 1'b0;
        repeat (14) step();
        mon_en = 1'b0;
        chk("b2b ALE count", ale_at.size(), 3);
        chk("b2b rsp count", rsp_at.size(), 3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("b2b T1 %0d", k),
                (k < ale_at.size()) ? ale_at[k] : -1, e + 1 + 4 * k);
            chk($sformatf("b2b T4 %0d", k),
                (k < rsp_at.size()) ? rsp_at[k] : -1, e + 4 + 4 * k);
        end
        chk("b2b last rdata", rsp_rdata, 8'h44);

        // Reset during T3 of a write with a queued request.
        req_write = 1'b1;
        req_io    = 1'b0;
        req_addr  = 20'h00180;
        req_wdata = 8'hEE;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        chk("rst-mid T1", ALE, 1);
        req_write = 1'b0;
        req_addr  = 20'h00010;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk("rst-mid queued", req_ready, 0);
        step();
        chk("rst-mid WR_T3", WR, 0);
        #2;
        RESET = 1'b1;
        #1;
        chk("rst-mid WR", WR, 1);
        chk("rst-mid busy", busy, 0);
        chk("rst-mid rsp_valid", rsp_valid, 0);
        chk("rst-mid ALE", ALE, 0);
        chk("rst-mid Address", Address, 0);
        chk("rst-mid CS0", CS0, 0);
        chk("rst-mid CS1", CS1, 0);
        chk("rst-mid hold dropped", req_ready, 1);
        chk("rst-mid rdata", rsp_rdata, 0);
        step();
        RESET = 1'b0;
        ale_at.delete();
        rsp_at.delete();
        mon_en = 1'b1;
        repeat (8) step();
        mon_en = 1'b0;
        chk("rst-mid no T1", ale_at.size(), 0);
        chk("rst-mid no rsp", rsp_at.size(), 0);
        chk("rst-mid idle", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
